mips_cpu_exec_unit: RTL and testbench

- Execute stage of the multicycle MIPS-I CPU: ALU-operation decoding, the 32-bit integer ALU, and the HI/LO multiply/divide unit in one block.
- Takes a 4-bit aluop from the main controller plus the instruction funct field.
- Produces a combinational result and a branch condition.
- Updates HI/LO on a clocked write strobe.

---
 rtl/mips_cpu_exec_unit.sv | 142 ++++++++++++++
 tb/tb_mips_cpu_exec_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mips_cpu_exec_unit.sv
// Execute stage of the multicycle MIPS-I CPU: ALU-op decode, 32-bit ALU and
// the HI/LO multiply/divide unit (single-cycle, combinational mul/div).
module mips_cpu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic [3:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shift,
  input  logic        muldivwrite,
  output logic [31:0] result,
  output logic        condition
);

  localparam logic [2:0] STATE_EXEC = 3'd3;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,  ALU_BEQ   = 4'd1,  ALU_RTYPE = 4'd2,  ALU_BNE   = 4'd3,
    ALU_ADDIU = 4'd4,  ALU_SLTI  = 4'd5,  ALU_SLTIU = 4'd6,  ALU_ANDI  = 4'd7,
    ALU_ORI   = 4'd8,  ALU_XORI  = 4'd9,  ALU_BLEZ  = 4'd10, ALU_BGTZ  = 4'd11,
    ALU_BLTZ  = 4'd12, ALU_BGEZ  = 4'd13, ALU_LUI   = 4'd14, ALU_PASSA = 4'd15
  } aluop_e;

  localparam logic [5:0] F_SLL   = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04, F_SRLV  = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08, F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20, F_ADDU  = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24, F_OR    = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A, F_SLTU  = 6'h2B;

  aluop_e      op;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sum, diff;
  logic        lt_s, lt_u;
  logic [4:0]  var_amt;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        div_ovf;
  logic        hilo_we;

  assign op      = aluop_e'(aluop);
  assign sum     = a + b;
  assign diff    = a - b;
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;
  assign var_amt = a[4:0];

  // Operands are explicitly widened so the product keeps all 64 bits.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor is forced non-zero so the divider never sees /0; the write is
  // suppressed for b==0 anyway. Most-negative / -1 is patched explicitly.
  assign divisor = (b == 32'd0) ? 32'd1 : b;
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign quot_s  = div_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(divisor));
  assign rem_s   = div_ovf ? 32'd0         : 32'($signed(a) % $signed(divisor));
  assign quot_u  = a / divisor;
  assign rem_u   = a % divisor;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    result    = '0;
    condition = 1'b0;
    unique case (op)
      ALU_ADD, ALU_ADDIU: result = sum;
      ALU_BEQ:   begin result = diff; condition = (a == b); end
      ALU_BNE:   begin result = diff; condition = (a != b); end
      ALU_SLTI:  result = {31'd0, lt_s};
      ALU_SLTIU: result = {31'd0, lt_u};
      ALU_ANDI:  result = a & b;
      ALU_ORI:   result = a | b;
      ALU_XORI:  result = a ^ b;
      ALU_BLEZ:  begin result = sum; condition = a[31] || (a == 32'd0); end
      ALU_BGTZ:  begin result = sum; condition = !a[31] && (a != 32'd0); end
      ALU_BLTZ:  begin result = sum; condition = a[31]; end
      ALU_BGEZ:  begin result = sum; condition = !a[31]; end
      ALU_LUI:   result = {b[15:0], 16'd0};
      ALU_PASSA: result = a;
      ALU_RTYPE: begin
        case (funct)
          F_SLL:                 result = b << shift;
          F_SRL:                 result = b >> shift;
          F_SRA:                 result = 32'($signed(b) >>> shift);
          F_SLLV:                result = b << var_amt;
          F_SRLV:                result = b >> var_amt;
          F_SRAV:                result = 32'($signed(b) >>> var_amt);
          F_JR, F_JALR:          result = a;
          F_MTHI, F_MTLO:        result = a;
          F_MFHI:                result = hi_q;
          F_MFLO:                result = lo_q;
          F_ADD, F_ADDU:         result = sum;
          F_SUB, F_SUBU:         result = diff;
          F_AND:                 result = a & b;
          F_OR:                  result = a | b;
          F_XOR:                 result = a ^ b;
          F_NOR:                 result = ~(a | b);
          F_SLT:                 result = {31'd0, lt_s};
          F_SLTU:                result = {31'd0, lt_u};
          default:               result = '0;
        endcase
      end
      default: ;
    endcase
  end

  assign hilo_we = muldivwrite && (state == STATE_EXEC) && (op == ALU_RTYPE);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we) begin
      case (funct)
        F_MULT:  {hi_d, lo_d} = prod_s;
        F_MULTU: {hi_d, lo_d} = prod_u;
        F_DIV:   if (b != 32'd0) begin lo_d = quot_s; hi_d = rem_s; end
        F_DIVU:  if (b != 32'd0) begin lo_d = quot_u; hi_d = rem_u; end
        F_MTHI:  hi_d = a;
        F_MTLO:  lo_d = a;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset has priority
  // over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_exec_unit.sv
// Directed self-checking bench for mips_cpu_exec_unit: ALU ops, shifts,
// branch conditions and HI/LO multiply/divide/move behaviour.
module tb_mips_cpu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic [3:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [4:0]  shift;
  logic        muldivwrite;
  logic [31:0] result;
  logic        condition;

  int n_cmp = 0;
  int n_bad = 0;

  mips_cpu_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .aluop       (aluop),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .shift       (shift),
    .muldivwrite (muldivwrite),
    .result      (result),
    .condition   (condition)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] va,
                     input logic [31:0] vb, input logic [4:0] sh);
    aluop = op; funct = fn; a = va; b = vb; shift = sh;
    #1;
  endtask

  // One clock edge with the strobe raised, then drop it.
  task automatic hilo_write(input logic [5:0] fn, input logic [31:0] va,
                            input logic [31:0] vb, input logic [2:0] st);
    aluop = 4'd2; funct = fn; a = va; b = vb; state = st; muldivwrite = 1'b1;
    @(posedge clk); #1;
    muldivwrite = 1'b0; state = 3'd0;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    alu(4'd2, 6'h10, 32'd0, 32'd0, 5'd0);
    check({tag, ".hi"}, result, hi);
    alu(4'd2, 6'h12, 32'd0, 32'd0, 5'd0);
    check({tag, ".lo"}, result, lo);
  endtask

  initial begin
    reset = 1'b1; state = 3'd0; aluop = 4'd0; funct = 6'd0;
    a = '0; b = '0; shift = '0; muldivwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_hilo("reset", 32'd0, 32'd0);

    // R-type arithmetic / logic
    alu(4'd2, 6'h21, 32'hFFFF_FFFF, 32'd2, 5'd0);       check("addu_wrap", result, 32'd1);
    alu(4'd2, 6'h23, 32'd0, 32'd1, 5'd0);               check("subu_wrap", result, 32'hFFFF_FFFF);
    alu(4'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0);       check("slt", result, 32'd1);
    alu(4'd2, 6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0);       check("sltu", result, 32'd0);
    alu(4'd2, 6'h27, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0); check("nor", result, 32'h0000_0F0F);
    alu(4'd2, 6'h08, 32'h0040_0010, 32'd5, 5'd0);       check("jr", result, 32'h0040_0010);
    alu(4'd2, 6'h3F, 32'd7, 32'd9, 5'd0);               check("bad_funct", result, 32'd0);
    alu(4'd2, 6'h21, 32'd7, 32'd9, 5'd0);               check("rtype_cond", {31'd0, condition}, 32'd0);

    // Shifts
    alu(4'd2, 6'h03, 32'd0, 32'h8000_0000, 5'd4);       check("sra", result, 32'hF800_0000);
    alu(4'd2, 6'h02, 32'd0, 32'h8000_0000, 5'd4);       check("srl", result, 32'h0800_0000);
    alu(4'd2, 6'h04, 32'd33, 32'h8000_0003, 5'd0);      check("sllv_mod32", result, 32'h0000_0006);
    alu(4'd2, 6'h00, 32'd0, 32'h1234_5678, 5'd0);       check("sll_zero", result, 32'h1234_5678);
    alu(4'd2, 6'h07, 32'd8, 32'h8000_1000, 5'd0);       check("srav", result, 32'hFF80_0010);

    // I-type ops
    alu(4'd14, 6'd0, 32'd0, 32'h0000_1234, 5'd0);       check("lui", result, 32'h1234_0000);
    alu(4'd5, 6'd0, 32'hFFFF_FFFE, 32'd3, 5'd0);        check("slti", result, 32'd1);
    alu(4'd6, 6'd0, 32'hFFFF_FFFE, 32'd3, 5'd0);        check("sltiu", result, 32'd0);
    alu(4'd9, 6'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0); check("xori", result, 32'hF0F0_F0F0);
    alu(4'd15, 6'd0, 32'hDEAD_BEEF, 32'd1, 5'd0);       check("pass_a", result, 32'hDEAD_BEEF);
    alu(4'd0, 6'd0, 32'd5, 32'd5, 5'd0);                check("add_cond", {31'd0, condition}, 32'd0);

    // Branch conditions
    alu(4'd1, 6'd0, 32'd5, 32'd5, 5'd0);                check("beq_cond", {31'd0, condition}, 32'd1);
    check("beq_result", result, 32'd0);
    alu(4'd3, 6'd0, 32'd5, 32'd5, 5'd0);                check("bne_cond", {31'd0, condition}, 32'd0);
    alu(4'd10, 6'd0, 32'd0, 32'd4, 5'd0);               check("blez_zero", {31'd0, condition}, 32'd1);
    check("blez_result", result, 32'd4);
    alu(4'd11, 6'd0, 32'd0, 32'd4, 5'd0);               check("bgtz_zero", {31'd0, condition}, 32'd0);
    alu(4'd11, 6'd0, 32'd1, 32'd4, 5'd0);               check("bgtz_pos", {31'd0, condition}, 32'd1);
    alu(4'd12, 6'd0, 32'h8000_0000, 32'd0, 5'd0);       check("bltz_neg", {31'd0, condition}, 32'd1);
    alu(4'd13, 6'd0, 32'h8000_0000, 32'd0, 5'd0);       check("bgez_neg", {31'd0, condition}, 32'd0);

    // Multiply / divide
    hilo_write(6'h18, 32'hFFFF_FFFD, 32'd7, 3'd3);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    alu(4'd2, 6'h18, 32'd3, 32'd7, 5'd0);               check("mult_result", result, 32'd0);
    hilo_write(6'h19, 32'hFFFF_FFFF, 32'd2, 3'd3);
    check_hilo("multu", 32'd1, 32'hFFFF_FFFE);
    hilo_write(6'h1A, 32'hFFFF_FFF9, 32'd2, 3'd3);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hilo_write(6'h1A, 32'd100, 32'd0, 3'd3);
    check_hilo("div_by_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hilo_write(6'h11, 32'h0000_0055, 32'd0, 3'd2);
    check_hilo("wrong_state", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hilo_write(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);
    hilo_write(6'h1B, 32'd100, 32'd7, 3'd3);
    check_hilo("divu", 32'd2, 32'd14);
    hilo_write(6'h13, 32'h0000_0077, 32'd0, 3'd3);
    check_hilo("mtlo", 32'd2, 32'h0000_0077);

    // Reset clears HI/LO, including when colliding with a write
    hilo_write(6'h11, 32'h0000_00AA, 32'd0, 3'd3);
    check_hilo("mthi", 32'h0000_00AA, 32'h0000_0077);
    reset = 1'b1;
    hilo_write(6'h13, 32'h0000_0099, 32'd0, 3'd3);
    reset = 1'b0;
    check_hilo("reset_wins", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
